// File: rtl/pmem_loader_pkg.sv
// Shared CPU package: CPU state encodings, program-load state machine encoding
// and the field constants of the byte-serial program-load frame.
package pmem_loader_pkg;

    localparam int DATA_W    = 12;
    localparam int BYTE_W    = 8;
    localparam int HI_BITS   = DATA_W - BYTE_W;
    localparam int MAX_WORDS = 256;
    localparam int CNT_W     = 9;

    typedef enum logic [1:0] {
        CPU_RESET,
        CPU_FETCH,
        CPU_EXEC,
        CPU_LOAD
    } cpu_state_e;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_COUNT,
        LD_HI,
        LD_LO,
        LD_CHECK,
        LD_DONE,
        LD_ERR
    } ld_state_e;

    // A COUNT byte of zero means "fill the whole memory", capped at 256 words.
    function automatic logic [CNT_W-1:0] frame_words(input logic [BYTE_W-1:0] n,
                                                     input int addr_w);
        if (n != '0) begin
            return {1'b0, n};
        end
        if (addr_w >= 8) begin
            return CNT_W'(MAX_WORDS);
        end
        return CNT_W'(1 << addr_w);
    endfunction

endpackage

// File: rtl/pmem_loader_if.sv
// Byte-stream input and program-memory write port of the loader.
// The loader connects through the slave modport; the environment uses the master one.
interface pmem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]                        in_data;
    logic                              in_valid;
    logic                              in_ready;
    logic                              pmem_we;
    logic [ADDR_W-1:0]                 pmem_addr;
    logic [pmem_loader_pkg::DATA_W-1:0] pmem_wdata;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output pmem_we,
        output pmem_addr,
        output pmem_wdata
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  pmem_we,
        input  pmem_addr,
        input  pmem_wdata
    );
endinterface

// File: rtl/pmem_loader.sv
// Program-memory loader: parses {COUNT, N x {HI,LO}, CHK} frames into 12-bit writes, 1-cycle write latency.
// in_ready depends on state only; in_valid stalls of any length freeze the parser.
module pmem_loader
    import pmem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    pmem_loader_if.slave bus,
    output logic         load_en,
    output logic         done,
    output logic         error
);

    ld_state_e                state_q, state_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BYTE_W-1:0]        sum_q, sum_d;
    logic [HI_BITS-1:0]       hi_q, hi_d;
    logic                     we_q, we_d;
    logic [ADDR_W-1:0]        waddr_q, waddr_d;
    logic [DATA_W-1:0]        wdata_q, wdata_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;

    logic                     in_ready;
    logic                     xfer;

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            LD_COUNT, LD_HI, LD_LO, LD_CHECK: in_ready = 1'b1;
            default:                          in_ready = 1'b0;
        endcase
    end

    assign xfer = bus.in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        hi_d    = hi_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        error_d = error_q;

        case (state_q)
            LD_IDLE: begin
                if (start) begin
                    state_d = LD_COUNT;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    addr_d  = '0;
                    cnt_d   = '0;
                    sum_d   = '0;
                end
            end
            LD_COUNT: begin
                if (xfer) begin
                    cnt_d   = frame_words(bus.in_data, ADDR_W);
                    sum_d   = sum_q + bus.in_data;
                    state_d = LD_HI;
                end
            end
            LD_HI: begin
                if (xfer) begin
                    if (bus.in_data[7:4] != '0) begin
                        state_d = LD_ERR;
                        error_d = 1'b1;
                    end else begin
                        hi_d    = bus.in_data[HI_BITS-1:0];
                        sum_d   = sum_q + bus.in_data;
                        state_d = LD_LO;
                    end
                end
            end
            LD_LO: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = {hi_q, bus.in_data};
                    addr_d  = addr_q + 1'b1;
                    sum_d   = sum_q + bus.in_data;
                    cnt_d   = cnt_q - 1'b1;
                    state_d = (cnt_q > CNT_W'(1)) ? LD_HI : LD_CHECK;
                end
            end
            LD_CHECK: begin
                if (xfer) begin
                    if (bus.in_data == sum_q) begin
                        state_d = LD_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LD_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            LD_DONE: state_d = LD_IDLE;
            LD_ERR:  state_d = LD_IDLE;
            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LD_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            hi_q    <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            hi_q    <= hi_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // A pending write is dropped the moment reset is raised, so a mid-frame reset never writes.
    assign bus.pmem_we    = we_q && !rst;
    assign bus.pmem_addr  = waddr_q;
    assign bus.pmem_wdata = wdata_q;
    assign bus.in_ready   = in_ready;

    // The last write lands while the FSM already waits for CHK, so the strobe keeps load_en up too.
    assign load_en = in_ready || we_q;
    assign done    = done_q;
    assign error   = error_q;

endmodule

// File: doc/pmem_loader.md
PMEM_LOADER -- requirements
Module: pmem_loader

Interface
REQ-001 Parameter ADDR_W, default 8: program-memory address width; 2**ADDR_W words.
REQ-002 Parameter DATA_W, fixed 12: instruction word width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a program load; honoured only in IDLE.
REQ-006 in_data  input  8  byte stream carrying the load frame.
REQ-007 in_valid  input  1  in_data holds a byte.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 pmem_we  output  1  one-cycle program-memory write strobe.
REQ-010 pmem_addr  output  ADDR_W  write address.
REQ-011 pmem_wdata  output  12  instruction word to write.
REQ-012 load_en  output  1  high while a load is in progress; holds the CPU in its LOAD state.
REQ-013 done  output  1  load completed with a good checksum; sticky until the next start or rst.
REQ-014 error  output  1  load aborted; sticky until the next start or rst.

Function
REQ-015 A byte SHALL transfer only on a cycle with in_valid && in_ready; in_ready SHALL be combinational from state only, never from in_valid.
REQ-016 Frame format SHALL be: COUNT byte N (0 encodes 2**ADDR_W words, capped at 256), then N word pairs {HI, LO}, then one CHK byte.
REQ-017 Word assembly: pmem_wdata = {HI[3:0], LO[7:0]}; a HI byte with a nonzero HI[7:4] SHALL abort with error.
REQ-018 States SHALL be IDLE, COUNT, HI, LO, CHECK, DONE, ERR.
REQ-019 IDLE -> COUNT on start; done and error clear, the address counter resets to 0, and the checksum accumulator resets to 0.
REQ-020 COUNT -> HI on the COUNT byte transfer; the word counter loads N.
REQ-021 HI -> LO on a legal HI transfer; HI -> ERR on an illegal HI byte.
REQ-022 LO -> HI on the LO transfer if words remain after this one; otherwise LO -> CHECK.
REQ-023 Each LO transfer SHALL produce pmem_we=1 on the next cycle only, with pmem_addr equal to the current address and pmem_wdata equal to the assembled word; the address then increments.
REQ-024 Write latency SHALL be exactly 1 cycle from the LO acceptance edge.
REQ-025 The address SHALL wrap modulo 2**ADDR_W; with N=0 the final write goes to address 2**ADDR_W-1.
REQ-026 Checksum: an 8-bit modulo-256 sum over the COUNT, all HI and all LO bytes.
REQ-027 CHECK: on the CHK transfer, go to DONE if CHK equals the sum, else to ERR.
REQ-028 DONE asserts done, and ERR asserts error; both return to IDLE on the next cycle, with the flag held.
REQ-029 load_en SHALL be high in COUNT, HI, LO and CHECK, and also in the cycle carrying the final pmem_we.
REQ-030 in_ready SHALL be 1 in COUNT, HI, LO and CHECK, and 0 in IDLE, DONE and ERR.
REQ-031 start outside IDLE SHALL be ignored; in_valid in IDLE SHALL be ignored, with no byte consumed.
REQ-032 in_valid gaps (stalls) of any length SHALL NOT alter state, counters or the sum.
REQ-033 Words already written before an abort SHALL remain written; no further pmem_we SHALL occur after entering ERR.

Reset
REQ-034 rst SHALL force IDLE, pmem_we=0, pmem_addr=0, pmem_wdata=0, load_en=0, done=0, error=0, counters=0, sum=0.
REQ-035 rst mid-frame SHALL abort silently: no write on the following cycle, and error stays 0.
REQ-036 rst has priority over start and over any byte transfer in the same cycle.

Structure
REQ-037 The loader state enum, DATA_W and the frame field constants SHALL live in the shared cpu package, next to the CPU state encodings.
REQ-038 The block is a single module with no sub-module; the FSM, the counters and the checksum are inline.

Verification
REQ-039 Load N=2 with words 0x812 and 0x0A5: bytes 02,08,12,00,A5,C1 -> writes (0,0x812) and (1,0x0A5), then done=1.
REQ-040 Same frame with CHK=C0 -> both writes occur, error=1, done=0.
REQ-041 HI byte 0x18 as the first word -> error=1, zero pmem_we pulses, in_ready=0 afterwards.
REQ-042 Random in_valid stalls of 0-5 cycles across the REQ-039 frame -> an identical write sequence and done=1.
REQ-043 rst asserted the cycle after the first LO acceptance -> no pmem_we, all outputs at reset values, error=0.
REQ-044 N=0 with ADDR_W=4 -> 16 writes at addresses 0..15 in order; a start pulse mid-load is ignored.
